// File: rtl/seg7_pkg.sv
// Shared constants, digit index type and active-low hex font for the seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned N_DIGITS  = 4;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  // Segment order {g,f,e,d,c,b,a}; 0 = segment lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (nibble)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Per-digit slot prescaler: counts 0..DIV-1 and asserts tick on the last count of each slot.
module seg7_prescaler #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with frame-aligned value commit.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         value_in,
  input  logic [N_DIGITS-1:0] dp_in,
  input  logic                value_valid,
  output logic                value_ready,
  input  logic                blank,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_done
);

  logic                tick;
  logic                boundary;
  logic                accept;
  digit_idx_t          idx_q;
  logic [15:0]         disp_q, pend_q;
  logic [N_DIGITS-1:0] dp_reg_q, pend_dp_q;
  logic                pend_full_q;
  logic                frame_done_q;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                show;

  seg7_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary    = tick && (idx_q == digit_idx_t'(N_DIGITS - 1));
  // Gated by rst so the slot reads as unavailable while reset is held.
  assign value_ready = !pend_full_q && !rst;
  assign accept      = value_valid && value_ready;

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] upper;
  always_comb begin
    upper = disp_q >> {idx_q, 2'b00};
    show  = (idx_q == '0) || (upper != '0) || dp_reg_q[idx_q];
  end
`else
  assign show = 1'b1;
`endif

  always_comb begin
    an_d  = (blank || !show) ? {N_DIGITS{1'b1}} : ~(N_DIGITS'(1) << idx_q);
    seg_d = hex_to_seg(disp_q[{idx_q, 2'b00} +: 4]);
    dp_d  = ~dp_reg_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      disp_q       <= '0;
      dp_reg_q     <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= {N_DIGITS{1'b1}};
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      if (tick) idx_q <= idx_q + 1'b1;
      frame_done_q <= boundary;
      // accept implies the slot was empty, so it never collides with a commit.
      if (accept) begin
        pend_q      <= value_in;
        pend_dp_q   <= dp_in;
        pend_full_q <= 1'b1;
      end else if (boundary && pend_full_q) begin
        disp_q      <= pend_q;
        dp_reg_q    <= pend_dp_q;
        pend_full_q <= 1'b0;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with DIV=4 (16-cycle frames).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] an_scan [4];
  logic [6:0] seg_1234 [4];

  seg7_scan_driver #(
    .DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank       (blank),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    tests_run++;
    if (frame_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
    end
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] d);
    int n = 0;
    value_in    = v;
    dp_in       = d;
    value_valid = 1'b1;
    while (value_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    tests_run++;
    if (value_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: value_ready=%b after %0d cycles, required 1", value_ready, n);
    end
    step();
    value_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({an, seg, dp, value_ready, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: an=%b seg=%b dp=%b rdy=%b fd=%b, required 1111 1111111 1 0 0",
               an, seg, dp, value_ready, frame_done);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (value_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after: value_ready=%b, required 1", value_ready);
    end
  endtask

  task automatic test_scan();
    send(16'h1234, 4'b0000);
    wait_frame();
    step();
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (an !== an_scan[i/4] || seg !== seg_1234[i/4] || dp !== 1'b1) begin
        tests_failed++;
        $display("FAIL scan_1234[%0d]: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1",
                 i, an, seg, dp, an_scan[i/4], seg_1234[i/4]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    value_in    = 16'h00AA;
    dp_in       = 4'b0000;
    value_valid = 1'b1;
    tests_run++;
    if (value_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first_ready: value_ready=%b, required 1", value_ready);
    end
    step();
    value_in = 16'h0055;
    tests_run++;
    if (value_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_hold: value_ready=%b, required 0", value_ready);
    end
    while (value_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    tests_run++;
    if (value_ready !== 1'b1 || frame_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_release: ready=%b frame_done=%b, required 1 1", value_ready, frame_done);
    end
    step();
    value_valid = 1'b0;
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b0001000) begin
      tests_failed++;
      $display("FAIL b2b_aa_d0: an=%b seg=%b, required 1110 0001000", an, seg);
    end
    repeat (4) step();
    tests_run++;
    if (an !== 4'b1101 || seg !== 7'b0001000) begin
      tests_failed++;
      $display("FAIL b2b_aa_d1: an=%b seg=%b, required 1101 0001000", an, seg);
    end
    wait_frame();
    step();
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b0010010) begin
      tests_failed++;
      $display("FAIL b2b_55_d0: an=%b seg=%b, required 1110 0010010", an, seg);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    wait_frame();
    value_in    = 16'hBEEF;
    dp_in       = 4'b1111;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({an, seg, dp, value_ready, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_outputs: an=%b seg=%b dp=%b rdy=%b fd=%b, required 1111 1111111 1 0 0",
               an, seg, dp, value_ready, frame_done);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (value_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_ready: value_ready=%b, required 1", value_ready);
    end
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL midrst_frame_len: first frame_done after %0d cycles, required 16", n);
    end
    step();
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pending_lost: an=%b seg=%b dp=%b, required 1110 1000000 1", an, seg, dp);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    send(16'h0005, 4'b0000);
    wait_frame();
    step();
    for (int i = 0; i < 16; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      an_exp  = (i < 4) ? 4'b1110 : 4'b1111;
`else
      an_exp  = an_scan[i/4];
`endif
      seg_exp = (i < 4) ? 7'b0010010 : 7'b1000000;
      tests_run++;
      if (an !== an_exp || seg !== seg_exp || dp !== 1'b1) begin
        tests_failed++;
        $display("FAIL lead_zero[%0d]: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1",
                 i, an, seg, dp, an_exp, seg_exp);
      end
      step();
    end
  endtask

  task automatic test_blank();
    int n = 1;
    send(16'h1234, 4'b0010);
    wait_frame();
    step();
    repeat (4) step();
    tests_run++;
    if (an !== 4'b1101 || dp !== 1'b0 || seg !== 7'b0110000) begin
      tests_failed++;
      $display("FAIL blank_pre_dp: an=%b seg=%b dp=%b, required 1101 0110000 0", an, seg, dp);
    end
    step();
    blank = 1'b1;
    step();
    tests_run++;
    if (an !== 4'hF || seg !== 7'b0110000) begin
      tests_failed++;
      $display("FAIL blank_an_off: an=%b seg=%b, required 1111 0110000", an, seg);
    end
    repeat (2) step();
    tests_run++;
    if (an !== 4'hF || seg !== 7'b0100100 || dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL blank_seg_runs: an=%b seg=%b dp=%b, required 1111 0100100 1", an, seg, dp);
    end
    wait_frame();
    value_in    = 16'hABCD;
    dp_in       = 4'b0000;
    value_valid = 1'b1;
    tests_run++;
    if (value_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL blank_ready: value_ready=%b, required 1", value_ready);
    end
    step();
    value_valid = 1'b0;
    tests_run++;
    if (value_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL blank_accepted: value_ready=%b, required 0", value_ready);
    end
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 16 || value_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL blank_frame: period=%0d ready=%b, required 16 1", n, value_ready);
    end
    blank = 1'b0;
    step();
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b0100001) begin
      tests_failed++;
      $display("FAIL blank_release: an=%b seg=%b, required 1110 0100001", an, seg);
    end
  endtask

  initial begin
    an_scan[0]  = 4'b1110;
    an_scan[1]  = 4'b1101;
    an_scan[2]  = 4'b1011;
    an_scan[3]  = 4'b0111;
    seg_1234[0] = 7'b0011001;
    seg_1234[1] = 7'b0110000;
    seg_1234[2] = 7'b0100100;
    seg_1234[3] = 7'b1111001;
    @(negedge clk);
    test_reset();
    test_scan();
    test_back_to_back();
    test_reset_mid_frame();
    test_leading_zero();
    test_blank();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
